// File: rtl/spi_crc_slave_pkg.sv
// Shared widths, frame lengths and FSM type for the SPI+CRC link.
// SPI_CRC_CHECK_EN selects 72-bit frames with CRC-8; otherwise 64-bit frames without CRC.
package spi_crc_pkg;
  localparam int CMD_W  = 8;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int CRC_W  = 8;
  localparam int CNT_W  = 7;

`ifdef SPI_CRC_CHECK_EN
  localparam int PAYLOAD_BITS = CMD_W + ADDR_W + DATA_W;
  localparam int FRAME_BITS   = PAYLOAD_BITS + CRC_W;
  localparam int LOOP_BITS    = DATA_W + CRC_W;
`else
  localparam int PAYLOAD_BITS = CMD_W + ADDR_W + DATA_W;
  localparam int FRAME_BITS   = PAYLOAD_BITS;
  localparam int LOOP_BITS    = DATA_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // One MSB-first CRC-8 step, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din,
                                           input logic [7:0] poly);
    crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? poly : 8'h00);
  endfunction
endpackage

// File: rtl/spi_crc_slave_if.sv
// SPI pins plus decoded receive fields of the SPI+CRC slave.
interface spi_crc_slave_if;
  import spi_crc_pkg::*;

  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [CMD_W-1:0]  rx_cmd;
  logic [ADDR_W-1:0] rx_addr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              crc_ok;
  logic              frame_err;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, rx_cmd, rx_addr, rx_data, rx_valid, crc_ok, frame_err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, rx_cmd, rx_addr, rx_data, rx_valid, crc_ok, frame_err
  );
endinterface

// File: rtl/spi_crc_slave_crc8.sv
// Bit-serial CRC-8 (MSB first, no reflection, no final XOR), shared with the master side.
// init reloads the seed; en advances one bit; result is registered.
module crc8_serial
  import spi_crc_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);
  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = crc8_step(crc_q, din, POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
endmodule

// File: rtl/spi_crc_slave.sv
// Oversampled SPI mode-0 slave: captures cmd/addr/data(/CRC) frames, loops back previous data(+CRC) on MISO.
// Pulses appear SYNC_STAGES+2 clk after cs_n rises; SPI_CRC_CHECK_EN enables the CRC-8 byte and check.
module spi_crc_slave
  import spi_crc_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter logic [7:0] CRC_INIT    = 8'h00
) (
  input logic            clk,
  input logic            rst,
  spi_crc_slave_if.slave bus
);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int               DATA_LSB  = FRAME_BITS - PAYLOAD_BITS;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  rx_sh_q, rx_sh_d;
  logic [LOOP_BITS-1:0]   miso_sh_q, miso_sh_d;
  logic [CMD_W-1:0]       rx_cmd_q, rx_cmd_d;
  logic [ADDR_W-1:0]      rx_addr_q, rx_addr_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic [DATA_W-1:0]      loop_data_q, loop_data_d;
  logic                   crc_ok_q, crc_ok_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   miso_q, miso_d;

`ifdef SPI_CRC_CHECK_EN
  localparam logic [CNT_W-1:0] PAYLOAD_CNT = CNT_W'(PAYLOAD_BITS);
  logic [CRC_W-1:0] loop_crc_q, loop_crc_d;
  logic [CRC_W-1:0] crc_calc;
  logic             crc_init, crc_en;

  crc8_serial #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .din  (mosi_s),
    .crc  (crc_calc)
  );
`endif

  always_comb begin
    sclk_sync_d    = sclk_sync_q << 1;
    sclk_sync_d[0] = bus.sclk;
    cs_sync_d      = cs_sync_q << 1;
    cs_sync_d[0]   = bus.cs_n;
    mosi_sync_d    = mosi_sync_q << 1;
    mosi_sync_d[0] = bus.mosi;
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    miso_sh_d   = miso_sh_q;
    rx_cmd_d    = rx_cmd_q;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    loop_data_d = loop_data_q;
    crc_ok_d    = crc_ok_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef SPI_CRC_CHECK_EN
    loop_crc_d  = loop_crc_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
`ifdef SPI_CRC_CHECK_EN
          crc_init  = 1'b1;
          miso_sh_d = {loop_data_q, loop_crc_q};
`else
          miso_sh_d = loop_data_q;
`endif
        end
      end
      ST_SHIFT: begin
        // The sclk edge of this cycle is taken even if cs_n rises in the same cycle.
        if (sclk_rise) begin
          if (cnt_q < FRAME_CNT) begin
            rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], mosi_s};
          end
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
`ifdef SPI_CRC_CHECK_EN
          crc_en = (cnt_q < PAYLOAD_CNT);
`endif
        end
        if (sclk_fall) begin
          miso_sh_d = miso_sh_q << 1;
        end
        if (cs_rise) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (cnt_q == FRAME_CNT) begin
          rx_cmd_d    = rx_sh_q[FRAME_BITS-1 -: CMD_W];
          rx_addr_d   = rx_sh_q[FRAME_BITS-CMD_W-1 -: ADDR_W];
          rx_data_d   = rx_sh_q[DATA_LSB +: DATA_W];
          loop_data_d = rx_sh_q[DATA_LSB +: DATA_W];
          rx_valid_d  = 1'b1;
`ifdef SPI_CRC_CHECK_EN
          crc_ok_d    = (crc_calc == rx_sh_q[CRC_W-1:0]);
          loop_crc_d  = rx_sh_q[CRC_W-1:0];
`else
          crc_ok_d    = 1'b1;
`endif
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miso_d = (state_d == ST_SHIFT) ? miso_sh_d[LOOP_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      // cs_n chain resets low so a cs_n still held low after reset is not seen as a new falling edge.
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      miso_sh_q   <= '0;
      rx_cmd_q    <= '0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
      loop_data_q <= '0;
      crc_ok_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
`ifdef SPI_CRC_CHECK_EN
      loop_crc_q  <= '0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      miso_sh_q   <= miso_sh_d;
      rx_cmd_q    <= rx_cmd_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
      loop_data_q <= loop_data_d;
      crc_ok_q    <= crc_ok_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
`ifdef SPI_CRC_CHECK_EN
      loop_crc_q  <= loop_crc_d;
`endif
    end
  end

  assign bus.miso      = miso_q;
  assign bus.rx_cmd    = rx_cmd_q;
  assign bus.rx_addr   = rx_addr_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_crc_slave.sv
// Bench for spi_crc_slave: SPI master driver with random clk phase, frame-level reference model,
// and a per-cycle compare of the receive outputs.
module tb_spi_crc_slave;
  import spi_crc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_crc_slave_if bus();

  spi_crc_slave #(
    .SYNC_STAGES (2),
    .CRC_POLY    (8'h07),
    .CRC_INIT    (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_valid;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] data;
    bit          crc_ok;
  } ev_t;

`ifdef SPI_CRC_CHECK_EN
  localparam bit EXP_BAD_OK = 1'b0;
`else
  localparam bit EXP_BAD_OK = 1'b1;
`endif

  int          checks = 0;
  int          errors = 0;
  ev_t         evq[$];
  ev_t         cur_ev;
  logic [7:0]  exp_cmd = '0;
  logic [23:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_crc_ok = 1'b0;
  logic [39:0] model_loop = '0;
  logic [39:0] last_miso = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC-8: polynomial division of the n low bits of v, MSB first.
  function automatic logic [7:0] model_crc(input logic [71:0] v, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      if ((c[7] ^ v[i]) == 1'b1) c = {c[6:0], 1'b0} ^ 8'h07;
      else                       c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [71:0] mk(input logic [7:0] c, input logic [23:0] a,
                                     input logic [31:0] d, input logic [7:0] x);
    logic [63:0] p;
    p = {c, a, d};
`ifdef SPI_CRC_CHECK_EN
    return {p, model_crc({8'h00, p}, 64) ^ x};
`else
    return {8'h00, p} | {64'h0, x & 8'h00};
`endif
  endfunction

  task automatic wait_clk(input int n, input int ph);
    repeat (n) @(posedge clk);
    #ph;
  endtask

  // Compare process: receive fields every cycle, pulses against the expected event queue.
  always @(negedge clk) begin
    if (!rst) begin
      exp_cmd    = '0;
      exp_addr   = '0;
      exp_data   = '0;
      exp_crc_ok = 1'b0;
    end else begin
      if (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1) begin
        if (evq.size() == 0) begin
          check("unexpected_pulse", {62'h0, bus.rx_valid, bus.frame_err}, 64'h0);
        end else begin
          cur_ev = evq.pop_front();
          check("pulse_kind", {62'h0, bus.rx_valid, bus.frame_err},
                cur_ev.is_valid ? 64'h2 : 64'h1);
          if (cur_ev.is_valid) begin
            exp_cmd    = cur_ev.cmd;
            exp_addr   = cur_ev.addr;
            exp_data   = cur_ev.data;
            exp_crc_ok = cur_ev.crc_ok;
          end
        end
      end else begin
        check("no_pulse", {62'h0, bus.rx_valid, bus.frame_err}, 64'h0);
      end
      check("rx_cmd", bus.rx_cmd, exp_cmd);
      check("rx_addr", bus.rx_addr, exp_addr);
      check("rx_data", bus.rx_data, exp_data);
      check("crc_ok", bus.crc_ok, exp_crc_ok);
    end
  end

  task automatic send_frame(input logic [71:0] vec, input int nbits, input bit abort);
    int          ph;
    int          k;
    logic [39:0] got;
    logic [39:0] exp_loop;
    ev_t         e;
    ph       = $urandom_range(1, 9);
    got      = '0;
    exp_loop = model_loop;
    k        = (nbits < LOOP_BITS) ? nbits : LOOP_BITS;
    @(posedge clk);
    #ph;
    bus.cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = (i < FRAME_BITS) ? vec[FRAME_BITS-1-i] : 1'($urandom);
      wait_clk((i == 0) ? 6 : 4, ph);
      if (i < LOOP_BITS) got = {got[38:0], bus.miso};
      bus.sclk = 1'b1;
      wait_clk(4, ph);
      bus.sclk = 1'b0;
      if (abort && i == 29) begin
        wait_clk(2, ph);
        rst        = 1'b0;
        model_loop = '0;
        wait_clk(3, ph);
        rst = 1'b1;
        wait_clk(10, ph);
        check("abort_miso_idle", bus.miso, 64'h0);
        bus.cs_n = 1'b1;
        wait_clk(8, ph);
        return;
      end
    end
    wait_clk(6, ph);
    e.is_valid = (nbits == FRAME_BITS);
    e.cmd      = vec[FRAME_BITS-1 -: 8];
    e.addr     = vec[FRAME_BITS-9 -: 24];
    e.data     = vec[FRAME_BITS-33 -: 32];
`ifdef SPI_CRC_CHECK_EN
    e.crc_ok = (model_crc({8'h00, vec[71:8]}, 64) == vec[7:0]);
    if (e.is_valid) model_loop = {e.data, vec[7:0]};
`else
    e.crc_ok = 1'b1;
    if (e.is_valid) model_loop = {8'h00, e.data};
`endif
    evq.push_back(e);
    bus.cs_n = 1'b1;
    for (int t = 0; t < 12 && evq.size() != 0; t++) @(posedge clk);
    #1;
    check("pulse_timeout", evq.size(), 64'h0);
    evq.delete();
    last_miso = got;
    check("miso_loop", got, exp_loop >> (LOOP_BITS - k));
    check("miso_idle", bus.miso, 64'h0);
    wait_clk(3, ph);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] v;
    int          n;
    logic [7:0]  x;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst      = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_miso", bus.miso, 64'h0);
    check("rst_cmd", bus.rx_cmd, 64'h0);
    check("rst_addr", bus.rx_addr, 64'h0);
    check("rst_data", bus.rx_data, 64'h0);
    check("rst_valid", bus.rx_valid, 64'h0);
    check("rst_crc_ok", bus.crc_ok, 64'h0);
    check("rst_frame_err", bus.frame_err, 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);

    v = 72'h313233343536373839;
    check("model_crc_check", model_crc(v, 72), 64'hF4);
    v = 72'h01;
    check("model_crc_one", model_crc(v, 8), 64'h07);

    send_frame(mk(8'h00, 24'h123456, 32'hF0F0A5A5, 8'h00), FRAME_BITS, 1'b0);
    check("t1_addr", bus.rx_addr, 64'h123456);
    check("t1_data", bus.rx_data, 64'hF0F0A5A5);
    check("t1_crc_ok", bus.crc_ok, 64'h1);
    check("t1_loop_after_reset", last_miso, 64'h0);

    send_frame(mk(8'hFF, 24'hABCDEF, 32'hDEADBEEF, 8'h01), FRAME_BITS, 1'b0);
    check("t2_data", bus.rx_data, 64'hDEADBEEF);
    check("t2_crc_ok", bus.crc_ok, {63'h0, EXP_BAD_OK});
`ifdef SPI_CRC_CHECK_EN
    check("t2_loop_data", last_miso[39:8], 64'hF0F0A5A5);
`else
    check("t2_loop_data", last_miso[31:0], 64'hF0F0A5A5);
`endif

    send_frame(mk(8'h33, 24'h000001, 32'h0BADF00D, 8'h00), 40, 1'b0);
    check("t3_short_data", bus.rx_data, 64'hDEADBEEF);
    check("t3_short_crc_ok", bus.crc_ok, {63'h0, EXP_BAD_OK});

    send_frame(mk(8'h44, 24'h000002, 32'hCAFEF00D, 8'h00), FRAME_BITS + 3, 1'b0);
    check("t4_long_data", bus.rx_data, 64'hDEADBEEF);

    send_frame(mk(8'h11, 24'h222222, 32'h33333333, 8'h00), FRAME_BITS, 1'b1);
    check("t5_abort_data", bus.rx_data, 64'h0);
    send_frame(mk(8'h5A, 24'h0BEEF0, 32'h12345678, 8'h00), FRAME_BITS, 1'b0);
    check("t5_cmd", bus.rx_cmd, 64'h5A);
    check("t5_crc_ok", bus.crc_ok, 64'h1);

    for (int f = 0; f < 100; f++) begin
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, FRAME_BITS + 4) : FRAME_BITS;
      send_frame(mk(8'($urandom), 24'($urandom), 32'($urandom), x), n, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
